// File: rtl/sem_pkg.sv
// rtl/sem_pkg.sv - shared state codes, counter width and default phase durations
package sem_pkg;

    localparam int W = 5;

    localparam int T_VERDE_P_DEF  = 20;
    localparam int T_AMARELO_DEF  = 4;
    localparam int T_VERMELHO_DEF = 2;
    localparam int T_VERDE_S_DEF  = 10;

    typedef enum logic [2:0] {
        ST_VERDE_P   = 3'd0,
        ST_AMARELO_P = 3'd1,
        ST_VERM1     = 3'd2,
        ST_VERDE_S   = 3'd3,
        ST_AMARELO_S = 3'd4,
        ST_VERM2     = 3'd5
    } estado_t;

endpackage

// File: rtl/sem_cruzamento_ctrl_contador.sv
// rtl/sem_cruzamento_ctrl_contador.sv - 5-bit loadable down counter that holds at zero
module contador_carga5b
    import sem_pkg::*;
#(
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         zero
);

    // Load wins over counting; the count parks at zero until the next load.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst)
            q <= RST_VAL;
        else if (load)
            q <= din;
        else if (q != '0)
            q <= q - W'(1);
    end

    assign zero = (q == '0);

endmodule

// File: rtl/sem_cruzamento_ctrl.sv
// rtl/sem_cruzamento_ctrl.sv - two-way intersection controller with demand-driven side service
module sem_cruzamento_ctrl
    import sem_pkg::*;
#(
    parameter int T_VERDE_P  = T_VERDE_P_DEF,
    parameter int T_AMARELO  = T_AMARELO_DEF,
    parameter int T_VERMELHO = T_VERMELHO_DEF,
    parameter int T_VERDE_S  = T_VERDE_S_DEF
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         ped_req,
    input  logic         car_side,
    output logic [W-1:0] S,
    output logic         pulso,
    output logic [2:0]   estado,
    output logic         VERMELHO_P,
    output logic         AMARELO_P,
    output logic         VERDE_P,
    output logic         VERMELHO_S,
    output logic         AMARELO_S,
    output logic         VERDE_S,
    output logic         ANDAR
);

    if (T_VERDE_P < 1 || T_VERDE_P > 31 || T_AMARELO < 1 || T_AMARELO > 31 ||
        T_VERMELHO < 1 || T_VERMELHO > 31 || T_VERDE_S < 1 || T_VERDE_S > 31) begin : g_param_check
        $error("sem_cruzamento_ctrl: phase durations must lie in 1..31");
    end

    localparam logic [W-1:0] LD_VERDE_P  = W'(T_VERDE_P - 1);
    localparam logic [W-1:0] LD_AMARELO  = W'(T_AMARELO - 1);
    localparam logic [W-1:0] LD_VERMELHO = W'(T_VERMELHO - 1);
    localparam logic [W-1:0] LD_VERDE_S  = W'(T_VERDE_S - 1);

    estado_t      st;
    estado_t      st_nxt;
    logic         pend;
    logic         demanda;
    logic         zero;
    logic         load;
    logic [W-1:0] din;
    logic         req;

    assign req     = ped_req | car_side;
    assign demanda = pend | req;

    contador_carga5b #(
        .RST_VAL (LD_VERDE_P)
    ) u_cnt (
        .ck   (ck),
        .rst  (rst),
        .load (load),
        .din  (din),
        .q    (S),
        .zero (zero)
    );

    assign pulso  = zero;
    assign estado = st;

    // Next state plus counter reload; every state change reloads the new phase length.
    always_comb begin
        st_nxt = st;
        din    = '0;
        unique case (st)
            ST_VERDE_P:   if (zero && demanda) st_nxt = ST_AMARELO_P;
            ST_AMARELO_P: if (zero) st_nxt = ST_VERM1;
            ST_VERM1:     if (zero) st_nxt = ST_VERDE_S;
            ST_VERDE_S:   if (zero) st_nxt = ST_AMARELO_S;
            ST_AMARELO_S: if (zero) st_nxt = ST_VERM2;
            ST_VERM2:     if (zero) st_nxt = ST_VERDE_P;
            default:      st_nxt = ST_VERM2;
        endcase
        case (st_nxt)
            ST_VERDE_P:                din = LD_VERDE_P;
            ST_AMARELO_P, ST_AMARELO_S: din = LD_AMARELO;
            ST_VERDE_S:                din = LD_VERDE_S;
            default:                   din = LD_VERMELHO;
        endcase
        load = (st_nxt != st);
    end

    // State register.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst)
            st <= ST_VERDE_P;
        else
            st <= st_nxt;
    end

    // Side-road request latch; cleared as side green starts, which also swallows a coincident request.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst)
            pend <= 1'b0;
        else if (st == ST_VERM1 && st_nxt == ST_VERDE_S)
            pend <= 1'b0;
        else if (req && st != ST_VERDE_S)
            pend <= 1'b1;
    end

    // Lamps registered from the next state so they change on the same edge as estado.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            {VERMELHO_P, AMARELO_P, VERDE_P} <= 3'b001;
            {VERMELHO_S, AMARELO_S, VERDE_S} <= 3'b100;
            ANDAR                            <= 1'b0;
        end else begin
            {VERMELHO_P, AMARELO_P, VERDE_P} <= 3'b100;
            {VERMELHO_S, AMARELO_S, VERDE_S} <= 3'b100;
            ANDAR                            <= 1'b0;
            case (st_nxt)
                ST_VERDE_P:   {VERMELHO_P, AMARELO_P, VERDE_P} <= 3'b001;
                ST_AMARELO_P: {VERMELHO_P, AMARELO_P, VERDE_P} <= 3'b010;
                ST_VERDE_S: begin
                    {VERMELHO_S, AMARELO_S, VERDE_S} <= 3'b001;
                    ANDAR                            <= 1'b1;
                end
                ST_AMARELO_S: {VERMELHO_S, AMARELO_S, VERDE_S} <= 3'b010;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sem_cruzamento_ctrl.sv
// tb/tb_sem_cruzamento_ctrl.sv - directed bench for sem_cruzamento_ctrl
module tb_sem_cruzamento_ctrl;

    logic       ck;
    logic       rst;
    logic       ped_req;
    logic       car_side;
    logic [4:0] S;
    logic       pulso;
    logic [2:0] estado;
    logic       VERMELHO_P, AMARELO_P, VERDE_P;
    logic       VERMELHO_S, AMARELO_S, VERDE_S;
    logic       ANDAR;

    int checks = 0;
    int errors = 0;

    sem_cruzamento_ctrl dut (
        .ck         (ck),
        .rst        (rst),
        .ped_req    (ped_req),
        .car_side   (car_side),
        .S          (S),
        .pulso      (pulso),
        .estado     (estado),
        .VERMELHO_P (VERMELHO_P),
        .AMARELO_P  (AMARELO_P),
        .VERDE_P    (VERDE_P),
        .VERMELHO_S (VERMELHO_S),
        .AMARELO_S  (AMARELO_S),
        .VERDE_S    (VERDE_S),
        .ANDAR      (ANDAR)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Main head {R,Y,G} and side head {R,Y,G} plus walk, as one 7-bit word.
    function automatic logic [31:0] lamps();
        return 32'({VERMELHO_P, AMARELO_P, VERDE_P, VERMELHO_S, AMARELO_S, VERDE_S, ANDAR});
    endfunction

    function automatic logic [31:0] exp_lamps(input int st);
        case (st)
            0:       return 32'b001_100_0;
            1:       return 32'b010_100_0;
            3:       return 32'b100_001_1;
            4:       return 32'b100_010_0;
            default: return 32'b100_100_0;
        endcase
    endfunction

    // Served cycle with a request at cycle 5: hand-derived phase boundaries.
    function automatic int exp_st(input int c);
        if (c < 20) return 0;
        if (c < 24) return 1;
        if (c < 26) return 2;
        if (c < 36) return 3;
        if (c < 40) return 4;
        if (c < 42) return 5;
        return 0;
    endfunction

    function automatic int exp_s(input int c);
        if (c < 20) return 19 - c;
        if (c < 24) return 23 - c;
        if (c < 26) return 25 - c;
        if (c < 36) return 35 - c;
        if (c < 40) return 39 - c;
        if (c < 42) return 41 - c;
        return 19;
    endfunction

    initial begin
        rst      = 1'b1;
        ped_req  = 1'b0;
        car_side = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_estado", 32'(estado), 0);
        chk("rst_S", 32'(S), 19);
        chk("rst_pulso", 32'(pulso), 0);
        chk("rst_lamps", lamps(), exp_lamps(0));
        chk("rst_pend", 32'(dut.pend), 0);
        repeat (3) step();
        chk("rst_hold_S", 32'(S), 19);

        // Idle: count 19 -> 0, then park at zero with main green.
        rst = 1'b1;
        chk("idle_S0", 32'(S), 19);
        for (int k = 1; k <= 19; k++) begin
            step();
            chk("idle_count", 32'(S), 32'(19 - k));
        end
        chk("idle_pulso", 32'(pulso), 1);
        for (int k = 0; k < 50; k++) begin
            step();
            chk("idle_hold", {24'd0, estado, S}, {24'd0, 3'd0, 5'd0});
            chk("idle_hold_pulso", 32'(pulso), 1);
            chk("idle_hold_lamps", lamps(), exp_lamps(0));
        end

        // Pedestrian pulse at cycle 5 from a fresh reset.
        @(posedge ck);
        #1 rst = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 0; c <= 42; c++) begin
            chk("ped_estado", 32'(estado), 32'(exp_st(c)));
            chk("ped_S", 32'(S), 32'(exp_s(c)));
            chk("ped_lamps", lamps(), exp_lamps(exp_st(c)));
            ped_req = (c == 5);
            step();
        end
        ped_req = 1'b0;
        repeat (18) step();
        chk("after_serve_S", 32'(S), 0);
        chk("after_serve_estado", 32'(estado), 0);

        // Car request while parked at zero: yellow on the very next edge.
        car_side = 1'b1;
        step();
        car_side = 1'b0;
        chk("late_estado", 32'(estado), 1);
        chk("late_S", 32'(S), 3);
        chk("late_lamps", lamps(), exp_lamps(1));

        // Request held through the whole side green is dropped.
        repeat (6) step();
        chk("vs_entry", 32'(estado), 3);
        chk("vs_entry_S", 32'(S), 9);
        ped_req = 1'b1;
        repeat (10) step();
        ped_req = 1'b0;
        chk("vs_drop_estado", 32'(estado), 4);
        chk("vs_drop_pend", 32'(dut.pend), 0);
        repeat (6) step();
        chk("vs_back_vp", {24'd0, estado, S}, {24'd0, 3'd0, 5'd19});
        repeat (24) step();
        chk("vs_no_yellow", {24'd0, estado, S}, {24'd0, 3'd0, 5'd0});
        chk("vs_no_yellow_lamps", lamps(), exp_lamps(0));

        // Request during side yellow is latched and served after a full main green.
        car_side = 1'b1;
        step();
        car_side = 1'b0;
        repeat (16) step();
        chk("as_entry", 32'(estado), 4);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("as_pend", 32'(dut.pend), 1);
        repeat (5) step();
        chk("as_vp_entry", {24'd0, estado, S}, {24'd0, 3'd0, 5'd19});
        for (int k = 1; k < 20; k++) begin
            step();
            chk("as_vp_stay", 32'(estado), 0);
        end
        step();
        chk("as_yellow", 32'(estado), 1);
        chk("as_yellow_S", 32'(S), 3);

        // Asynchronous reset mid side green, between clock edges.
        repeat (9) step();
        chk("ar_pre_estado", 32'(estado), 3);
        chk("ar_pre_andar", 32'(ANDAR), 1);
        #3 rst = 1'b0;
        #1;
        chk("ar_estado", 32'(estado), 0);
        chk("ar_S", 32'(S), 19);
        chk("ar_pulso", 32'(pulso), 0);
        chk("ar_lamps", lamps(), exp_lamps(0));
        chk("ar_pend", 32'(dut.pend), 0);
        step();
        rst = 1'b1;
        step();
        chk("ar_release_S", 32'(S), 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
